vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- Raster timing engine for the 640x480@60 Hz VGA path, running on the 25 MHz pixel clock.
- Generates hsync/vsync and issues pixel coordinates to the colour/pattern generator.
- Takes back that generator's registered 16-bit RGB565 colour and drives it to the DAC/pins.
- Absorbs the generator's fixed 1-cycle latency by requesting each pixel one clock ahead of display.

Parameters:
H_SYNC, 96, hsync pulse width in clocks
H_BACK, 48, horizontal back porch
H_VALID, 640, active pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
V_VALID, 480, active lines per frame
V_FRONT, 10, vertical front porch

Ports:
Clk_int  in  1  pixel clock, 25 MHz
Sys_Rst_n  in  1  reset
en  in  1  run request; level-sensitive
pix_data  in  16  RGB565 from generator, valid 1 clock after pix_req
pix_req  out  1  coordinate request to generator
pix_x  out  10  requested X, 0..H_VALID-1; 0 when pix_req=0
pix_y  out  10  requested Y, 0..V_VALID-1; 0 when pix_req=0
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
rgb  out  16  displayed colour; 0 outside active video
rgb_valid  out  1  active-video flag
frame_start  out  1  1-cycle pulse at h_cnt=0, v_cnt=0 while running
busy  out  1  state is not IDLE

Behaviour:
- Reset: Sys_Rst_n, asynchronous, active-low; clock Clk_int.
- Reset values: state=IDLE, h_cnt=0, v_cnt=0.
- Reset output values: hsync=1, vsync=1, rgb=0, rgb_valid=0, pix_req=0, pix_x=0, pix_y=0, frame_start=0, busy=0.
- Derived constants: H_TOTAL=H_SYNC+H_BACK+H_VALID+H_FRONT=800; V_TOTAL=525; HS=H_SYNC+H_BACK=144; VS=V_SYNC+V_BACK=35.
- Counters, in RUN/DRAIN:
  - h_cnt increments every clock and wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt=H_TOTAL-1 and wraps V_TOTAL-1 -> 0.
  - In IDLE both counters are held at 0.
- State machine, states IDLE, RUN, DRAIN:
  - IDLE -> RUN when en=1. The first RUN cycle has h_cnt=0, v_cnt=0, so frame_start=1 in that cycle.
  - RUN -> DRAIN when en=0, unless at frame end (h=H_TOTAL-1, v=V_TOTAL-1); at frame end with en=0, go RUN -> IDLE.
  - DRAIN -> IDLE at frame end. DRAIN -> RUN if en=1, with no counter disturbance.
  - Frames are never truncated by en.
- Decode while not IDLE; all decode is combinational from state/counters:
  - hsync = 0 when h_cnt < H_SYNC.
  - vsync = 0 when v_cnt < V_SYNC.
  - rgb_valid = 1 when HS <= h_cnt < HS+H_VALID and VS <= v_cnt < VS+V_VALID.
  - pix_req = 1 when HS-1 <= h_cnt < HS+H_VALID-1 and v_cnt is in the valid range.
  - pix_x = h_cnt-(HS-1); pix_y = v_cnt-VS.
- Datapath:
  - rgb = rgb_valid ? pix_data : 0.
  - The pixel requested at cycle t is displayed at cycle t+1.
- Subtractions are 10-bit and evaluated only under the corresponding enable; otherwise the output is 0.
- Reset asserted mid-frame: immediate return to reset values; the next en=1 starts a fresh frame at (0,0).
- frame_start: combinational, (state!=IDLE) & h_cnt=0 & v_cnt=0.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: rgb is forced to 16'hFFFF on active pixels where display x is 0 or H_VALID-1, or display y is 0 or V_VALID-1. Here x=h_cnt-HS and y=v_cnt-VS. Interior pixels pass pix_data unchanged; pix_req/pix_x/pix_y are unaffected.
- Undefined: no override; rgb = pix_data during active video.

Test Plan:
- Reset, en=0 for 100 clocks -> hsync=vsync=1, rgb=0, busy=0, pix_req=0 throughout.
- en=1 held, run 2 frames:
  - frame_start pulses exactly 420000 clocks apart.
  - hsync low 96 clocks per 800-clock line.
  - vsync low 1600 clocks (2 lines) per frame.
  - rgb_valid high 307200 clocks per frame.
- pix_data driven as a registered function of (pix_x, pix_y) with 1-clock latency, e.g. {pix_y[5:0], pix_x[9:0]} registered:
  - first rgb_valid cycle (h=144, v=35) shows x=0, y=0 data;
  - last active pixel (h=783, v=514) shows x=639, y=479 data;
  - pix_x=0 is issued at h=143;
  - rgb=0 at h=784.
- Drop en at h=400, v=200 -> state DRAIN, busy=1, timing continues to (799,524), then IDLE; no frame_start follows. Re-raise en in DRAIN at v=300 -> RUN, no counter glitch, next frame_start at the normal interval.
- Assert Sys_Rst_n=0 for 3 clocks at h=500, v=100 -> all outputs at reset values immediately. Release with en=1 -> frame_start on the first RUN clock.
- VGA_BORDER_EN defined, pix_data=16'h001F -> rgb=16'hFFFF at display pixels (0,0), (639,10) and (10,479); rgb=16'h001F at (1,1).

Source files
------------

// File: rtl/vga_timing_ctrl_if.sv
// Pixel-side bus of the VGA timing engine.
// master: the timing engine (takes run request and generator colour, drives
//         the coordinate request and the display-side outputs).
// slave : the surroundings (control, pattern generator, DAC/pins).
interface vga_timing_ctrl_if;
   logic        en;
   logic [15:0] pix_data;
   logic        pix_req;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        hsync;
   logic        vsync;
   logic [15:0] rgb;
   logic        rgb_valid;
   logic        frame_start;
   logic        busy;

   modport master (
      input  en,
      input  pix_data,
      output pix_req,
      output pix_x,
      output pix_y,
      output hsync,
      output vsync,
      output rgb,
      output rgb_valid,
      output frame_start,
      output busy
   );

   modport slave (
      output en,
      output pix_data,
      input  pix_req,
      input  pix_x,
      input  pix_y,
      input  hsync,
      input  vsync,
      input  rgb,
      input  rgb_valid,
      input  frame_start,
      input  busy
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Raster timing engine for the 640x480@60 Hz VGA path (25 MHz pixel clock).
// Counts h/v position, decodes syncs and active video, requests each pixel
// one clock ahead so the generator's registered colour lines up with display.
// Optional build macro VGA_BORDER_EN: paints a white 1-pixel frame around the
// active area instead of the generator colour on edge pixels.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped, counters held at 0, all outputs at rest levels
// RUN   | free-running raster, en high
// DRAIN | en dropped mid-frame; finish the frame, then stop
module vga_timing_ctrl #(
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int H_VALID = 640,
   parameter int H_FRONT = 16,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33,
   parameter int V_VALID = 480,
   parameter int V_FRONT = 10
) (
   input logic               Clk_int,
   input logic               Sys_Rst_n,
   vga_timing_ctrl_if.master bus
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int HS      = H_SYNC + H_BACK;
   localparam int VS      = V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
   localparam logic [9:0] H_ACT_BEG = 10'(HS);
   localparam logic [9:0] H_ACT_END = 10'(HS + H_VALID);
   localparam logic [9:0] H_REQ_BEG = 10'(HS - 1);
   localparam logic [9:0] H_REQ_END = 10'(HS + H_VALID - 1);
   localparam logic [9:0] V_ACT_BEG = 10'(VS);
   localparam logic [9:0] V_ACT_END = 10'(VS + V_VALID);
`ifdef VGA_BORDER_EN
   localparam logic [9:0] X_MAX     = 10'(H_VALID - 1);
   localparam logic [9:0] Y_MAX     = 10'(V_VALID - 1);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t     state;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;

   logic       running;
   logic       line_end;
   logic       frame_end;
   logic       h_act;
   logic       v_act;
   logic       h_req;
   logic       act;
   logic       req;

   assign running   = (state != IDLE);
   assign line_end  = (h_cnt == H_LAST);
   assign frame_end = line_end && (v_cnt == V_LAST);

   // Sequencer and raster counters. DRAIN keeps the raster going so a frame
   // is never cut short; en=1 in DRAIN simply resumes RUN without touching
   // the counters. RUN and DRAIN share the same next-state rule.
   always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
      if (!Sys_Rst_n) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               h_cnt <= '0;
               v_cnt <= '0;
               if (bus.en) begin
                  state <= RUN;
               end
            end
            RUN, DRAIN: begin
               if (line_end) begin
                  h_cnt <= '0;
                  v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
               end else begin
                  h_cnt <= h_cnt + 10'd1;
               end

               if (bus.en) begin
                  state <= RUN;
               end else if (frame_end) begin
                  state <= IDLE;
               end else begin
                  state <= DRAIN;
               end
            end
            default: begin
               state <= IDLE;
               h_cnt <= '0;
               v_cnt <= '0;
            end
         endcase
      end
   end

   assign h_act = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
   assign v_act = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
   assign h_req = (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);
   assign act   = running && h_act && v_act;
   assign req   = running && h_req && v_act;

`ifdef VGA_BORDER_EN
   logic [9:0] disp_x;
   logic [9:0] disp_y;
   logic       on_border;

   // Display coordinates of the pixel currently shown, only meaningful in
   // active video; gated so they read 0 elsewhere.
   always_comb begin
      disp_x    = '0;
      disp_y    = '0;
      on_border = 1'b0;
      if (act) begin
         disp_x    = h_cnt - H_ACT_BEG;
         disp_y    = v_cnt - V_ACT_BEG;
         on_border = (disp_x == 10'd0) || (disp_x == X_MAX) ||
                     (disp_y == 10'd0) || (disp_y == Y_MAX);
      end
   end
`endif

   // Output decode: syncs, active flag, one-ahead coordinate request and
   // the displayed colour, all straight from state and counters.
   always_comb begin
      bus.hsync       = 1'b1;
      bus.vsync       = 1'b1;
      bus.rgb_valid   = act;
      bus.pix_req     = req;
      bus.pix_x       = '0;
      bus.pix_y       = '0;
      bus.rgb         = '0;
      bus.frame_start = running && (h_cnt == 10'd0) && (v_cnt == 10'd0);
      bus.busy        = running;

      if (running && (h_cnt < H_SYNC_END)) begin
         bus.hsync = 1'b0;
      end
      if (running && (v_cnt < V_SYNC_END)) begin
         bus.vsync = 1'b0;
      end

      if (req) begin
         bus.pix_x = h_cnt - H_REQ_BEG;
         bus.pix_y = v_cnt - V_ACT_BEG;
      end

      if (act) begin
`ifdef VGA_BORDER_EN
         bus.rgb = on_border ? 16'hFFFF : bus.pix_data;
`else
         bus.rgb = bus.pix_data;
`endif
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with a scaled-down raster (54 x 15 clocks per
// frame) so several whole frames fit in a short run. Generator model returns
// {~y[5:0], x} registered one clock after the request, or a constant 16'h001F.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

   localparam int HT    = 54;
   localparam int VT    = 15;
   localparam int FRAME = HT * VT;

`ifdef VGA_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   typedef struct {
      int          h;
      int          v;
      bit          hs;
      bit          vs;
      bit          val;
      bit          req;
      int          px;
      int          py;
      bit          fs;
      logic [15:0] rgb;
      bit          brd;
   } vec_t;

   logic Clk_int;
   logic Sys_Rst_n;
   bit   gen_const;
   int   cyc;
   int   n_pass;
   int   n_total;

   vga_timing_ctrl_if vif ();

   vga_timing_ctrl #(
      .H_SYNC (12), .H_BACK (6), .H_VALID(32), .H_FRONT(4),
      .V_SYNC (2),  .V_BACK (3), .V_VALID(8),  .V_FRONT(2)
   ) dut (
      .Clk_int  (Clk_int),
      .Sys_Rst_n(Sys_Rst_n),
      .bus      (vif.master)
   );

   initial Clk_int = 1'b0;
   always #20 Clk_int = ~Clk_int;

   // registered colour generator, one clock behind pix_x/pix_y
   always @(posedge Clk_int)
      vif.pix_data <= gen_const ? 16'h001F : {~vif.pix_y[5:0], vif.pix_x};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      else
         n_pass++;
   endtask

   task automatic chk_all(input string tag, input bit hs, input bit vs, input bit val,
                          input bit req, input int px, input int py, input bit fs,
                          input logic [15:0] rgb, input bit bsy);
      chk({tag, ".hsync"},       32'(vif.hsync),       32'(hs));
      chk({tag, ".vsync"},       32'(vif.vsync),       32'(vs));
      chk({tag, ".rgb_valid"},   32'(vif.rgb_valid),   32'(val));
      chk({tag, ".pix_req"},     32'(vif.pix_req),     32'(req));
      chk({tag, ".pix_x"},       32'(vif.pix_x),       px);
      chk({tag, ".pix_y"},       32'(vif.pix_y),       py);
      chk({tag, ".frame_start"}, 32'(vif.frame_start), 32'(fs));
      chk({tag, ".rgb"},         32'(vif.rgb),         32'(rgb));
      chk({tag, ".busy"},        32'(vif.busy),        32'(bsy));
   endtask

   task automatic step();
      @(negedge Clk_int);
      cyc++;
   endtask

   task automatic goto(input int target);
      while (cyc < target) step();
   endtask

   function automatic vec_t mk(input int h, input int v, input bit hs, input bit vs,
                               input bit val, input bit req, input int px, input int py,
                               input bit fs, input logic [15:0] rgb, input bit brd);
      vec_t r;
      r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.val = val; r.req = req;
      r.px = px; r.py = py; r.fs = fs; r.rgb = rgb; r.brd = brd;
      return r;
   endfunction

   vec_t vecs[17];

   initial begin
      int viol, hs_low, vs_low, val_cnt, fs_cnt;
      int b, b2, b3, b4;
      logic [15:0] exp_rgb;
      logic [15:0] c_brd;

      // h, v, hsync, vsync, rgb_valid, pix_req, pix_x, pix_y, frame_start, rgb, border
      vecs[0]  = mk( 0,  0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 1'b1, 16'h0000, 1'b0);
      vecs[1]  = mk(11,  0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 1'b0, 16'h0000, 1'b0);
      vecs[2]  = mk(12,  0, 1'b1, 1'b0, 1'b0, 1'b0,  0, 0, 1'b0, 16'h0000, 1'b0);
      vecs[3]  = mk( 0,  2, 1'b0, 1'b1, 1'b0, 1'b0,  0, 0, 1'b0, 16'h0000, 1'b0);
      vecs[4]  = mk(17,  4, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0, 1'b0, 16'h0000, 1'b0);
      vecs[5]  = mk(17,  5, 1'b1, 1'b1, 1'b0, 1'b1,  0, 0, 1'b0, 16'h0000, 1'b0);
      vecs[6]  = mk(18,  5, 1'b1, 1'b1, 1'b1, 1'b1,  1, 0, 1'b0, 16'hFC00, 1'b1);
      vecs[7]  = mk(48,  5, 1'b1, 1'b1, 1'b1, 1'b1, 31, 0, 1'b0, 16'hFC1E, 1'b1);
      vecs[8]  = mk(49,  5, 1'b1, 1'b1, 1'b1, 1'b0,  0, 0, 1'b0, 16'hFC1F, 1'b1);
      vecs[9]  = mk(50,  5, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0, 1'b0, 16'h0000, 1'b0);
      vecs[10] = mk(19,  6, 1'b1, 1'b1, 1'b1, 1'b1,  2, 1, 1'b0, 16'hF801, 1'b0);
      vecs[11] = mk(17, 12, 1'b1, 1'b1, 1'b0, 1'b1,  0, 7, 1'b0, 16'h0000, 1'b0);
      vecs[12] = mk(49, 12, 1'b1, 1'b1, 1'b1, 1'b0,  0, 0, 1'b0, 16'hE01F, 1'b1);
      vecs[13] = mk(18, 13, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0, 1'b0, 16'h0000, 1'b0);
      vecs[14] = mk(53, 14, 1'b1, 1'b1, 1'b0, 1'b0,  0, 0, 1'b0, 16'h0000, 1'b0);
      vecs[15] = mk( 0, 15, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 1'b1, 16'h0000, 1'b0);
      vecs[16] = mk(20, 20, 1'b1, 1'b1, 1'b1, 1'b1,  3, 0, 1'b0, 16'hFC02, 1'b1);

      n_pass = 0; n_total = 0; cyc = 0;
      gen_const = 1'b0;
      vif.en    = 1'b0;
      Sys_Rst_n = 1'b0;
      repeat (3) @(negedge Clk_int);
      chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0000, 1'b0);
      Sys_Rst_n = 1'b1;

      // en low: engine must stay quiet
      viol = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1 || vif.rgb !== 16'h0 ||
             vif.busy !== 1'b0 || vif.pix_req !== 1'b0 || vif.frame_start !== 1'b0)
            viol++;
      end
      chk("idle_quiet", 32'(viol), 32'd0);

      // start: first RUN cycle is cycle 0 of frame 0
      vif.en = 1'b1;
      step();
      cyc = 0;
      for (int i = 0; i < 17; i++) begin
         goto(vecs[i].v * HT + vecs[i].h);
         exp_rgb = (BORDER && vecs[i].brd) ? 16'hFFFF : vecs[i].rgb;
         chk_all($sformatf("vec%0d", i), vecs[i].hs, vecs[i].vs, vecs[i].val, vecs[i].req,
                 vecs[i].px, vecs[i].py, vecs[i].fs, exp_rgb, 1'b1);
      end

      // whole-frame statistics over frame 2
      goto(2 * FRAME);
      chk("f2_start", 32'(vif.frame_start), 32'd1);
      hs_low = 0; vs_low = 0; val_cnt = 0; fs_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (!vif.hsync)      hs_low++;
         if (!vif.vsync)      vs_low++;
         if (vif.rgb_valid)   val_cnt++;
         if (vif.frame_start) fs_cnt++;
         step();
      end
      chk("hsync_low_per_frame", 32'(hs_low), 32'd180);
      chk("vsync_low_per_frame", 32'(vs_low), 32'd108);
      chk("valid_per_frame",     32'(val_cnt), 32'd256);
      chk("fs_per_frame",        32'(fs_cnt), 32'd1);
      chk("fs_interval",         32'(vif.frame_start), 32'd1);

      // frame 3: drop en mid-frame, re-raise while draining
      b = 3 * FRAME;
      goto(b + 8 * HT + 30);
      vif.en = 1'b0;
      step();
      chk("drain.busy", 32'(vif.busy), 32'd1);
      goto(b + 9 * HT + 5);
      chk("drain.hsync", 32'(vif.hsync), 32'd0);
      goto(b + 9 * HT + 20);
      chk("drain.rgb_valid", 32'(vif.rgb_valid), 32'd1);
      chk("drain.rgb", 32'(vif.rgb), 32'h0000EC02);
      goto(b + 10 * HT);
      vif.en = 1'b1;
      goto(b + FRAME);
      chk("resume.fs", 32'(vif.frame_start), 32'd1);
      chk("resume.busy", 32'(vif.busy), 32'd1);

      // frame 4: drop en and let it drain to IDLE
      b2 = 4 * FRAME;
      goto(b2 + 8 * HT + 30);
      vif.en = 1'b0;
      goto(b2 + FRAME - 1);
      chk("drain_end.busy", 32'(vif.busy), 32'd1);
      step();
      chk_all("after_drain", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0000, 1'b0);
      viol = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (vif.frame_start !== 1'b0 || vif.busy !== 1'b0) viol++;
      end
      chk("idle_no_fs", 32'(viol), 32'd0);

      // restart from IDLE, then reset mid-frame
      vif.en = 1'b1;
      step();
      b3 = cyc;
      chk("restart.fs", 32'(vif.frame_start), 32'd1);
      goto(b3 + 7 * HT + 30);
      chk("pre_rst.rgb_valid", 32'(vif.rgb_valid), 32'd1);
      Sys_Rst_n = 1'b0;
      #1;
      chk_all("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0000, 1'b0);
      repeat (3) step();
      Sys_Rst_n = 1'b1;
      step();
      b4 = cyc;
      chk("post_rst.fs", 32'(vif.frame_start), 32'd1);
      chk("post_rst.busy", 32'(vif.busy), 32'd1);
      chk("post_rst.hsync", 32'(vif.hsync), 32'd0);

      // border override with a constant generator colour
      gen_const = 1'b1;
      c_brd = BORDER ? 16'hFFFF : 16'h001F;
      goto(b4 + 5 * HT + 18);
      chk("brd(0,0)", 32'(vif.rgb), 32'(c_brd));
      goto(b4 + 6 * HT + 19);
      chk("brd(1,1)", 32'(vif.rgb), 32'h001F);
      goto(b4 + 7 * HT + 49);
      chk("brd(31,2)", 32'(vif.rgb), 32'(c_brd));
      goto(b4 + 12 * HT + 20);
      chk("brd(2,7)", 32'(vif.rgb), 32'(c_brd));
      chk("brd.pix_req", 32'(vif.pix_req), 32'd1);
      chk("brd.pix_x", 32'(vif.pix_x), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
